// File: rtl/lpif_ustrm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lpif_ustrm_pkg
// Description : Shared types and constants for the LPIF upstream receive buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package lpif_ustrm_pkg;

    localparam logic [7:0] LPIF_STATE_RESET = 8'h00;

    // One buffered upstream beat; the masks are already qualified by ustrm_valid.
    typedef struct packed {
        logic [1:0]   dvalid_mask;
        logic [1:0]   crc_valid;
        logic [7:0]   crc;
        logic [3:0]   protid;
        logic [255:0] data;
    } ustrm_entry_t;

endpackage
`default_nettype wire

// File: rtl/lpif_ustrm_state_track.sv
`default_nettype none
// ============================================================================
// Module      : lpif_ustrm_state_track
// Description : Tracks received LPIF state and pulses on change. Optional
//               two-sample glitch filter via LPIF_USTRM_STATE_FILTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module lpif_ustrm_state_track
    import lpif_ustrm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_sample_en,
    input  logic [7:0] i_state,
    output logic [7:0] o_state,
    output logic       o_state_chg
);

    logic [7:0] r_state;
    logic       r_state_chg;

`ifdef LPIF_USTRM_STATE_FILTER_EN
    logic [7:0] r_cand;
    logic       r_cand_vld;

    // Commit only when the previous differing sample repeats unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= LPIF_STATE_RESET;
            r_state_chg <= 1'b0;
            r_cand      <= LPIF_STATE_RESET;
            r_cand_vld  <= 1'b0;
        end else begin
            r_state_chg <= 1'b0;
            if (!i_sample_en || (i_state == r_state)) begin
                r_cand_vld <= 1'b0;
            end else if (r_cand_vld && (r_cand == i_state)) begin
                r_state     <= i_state;
                r_state_chg <= 1'b1;
                r_cand_vld  <= 1'b0;
            end else begin
                r_cand     <= i_state;
                r_cand_vld <= 1'b1;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= LPIF_STATE_RESET;
            r_state_chg <= 1'b0;
        end else begin
            r_state_chg <= 1'b0;
            if (i_sample_en && (i_state != r_state)) begin
                r_state     <= i_state;
                r_state_chg <= 1'b1;
            end
        end
    end
`endif

    assign o_state     = r_state;
    assign o_state_chg = r_state_chg;

endmodule
`default_nettype wire

// File: rtl/lpif_ustrm_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : lpif_ustrm_rx_buffer
// Description : Elastic FIFO for LPIF upstream beats with valid/ready output,
//               credit return and state tracking (LPIF_USTRM_STATE_FILTER_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module lpif_ustrm_rx_buffer
    import lpif_ustrm_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         clk_wr,
    input  logic         rst_wr,
    input  logic         rx_online,
    input  logic [7:0]   ustrm_state,
    input  logic [3:0]   ustrm_protid,
    input  logic [255:0] ustrm_data,
    input  logic [1:0]   ustrm_dvalid,
    input  logic [7:0]   ustrm_crc,
    input  logic [1:0]   ustrm_crc_valid,
    input  logic [1:0]   ustrm_valid,
    output logic         flit_valid,
    input  logic         flit_ready,
    output logic [255:0] flit_data,
    output logic [3:0]   flit_protid,
    output logic [7:0]   flit_crc,
    output logic [1:0]   flit_crc_valid,
    output logic [1:0]   flit_dvalid,
    output logic [7:0]   flit_state,
    output logic         state_chg,
    output logic         credit_return,
    output logic [AW:0]  fill_level,
    output logic         overflow
);

    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    ustrm_entry_t r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_fill;
    logic          r_overflow;
    logic          r_credit;

    ustrm_entry_t w_entry;
    ustrm_entry_t w_head;
    logic         w_push;
    logic         w_pop;
    logic         w_accept;

    assign w_push   = rx_online & |(ustrm_valid & ustrm_dvalid);
    assign w_pop    = (r_fill != '0) & flit_ready;
    assign w_accept = w_push & ((r_fill < c_depth) | w_pop);

    always_comb begin
        w_entry             = '0;
        w_entry.dvalid_mask = ustrm_valid & ustrm_dvalid;
        w_entry.crc_valid   = ustrm_crc_valid & ustrm_valid;
        w_entry.crc         = ustrm_crc;
        w_entry.protid      = ustrm_protid;
        w_entry.data        = ustrm_data;
    end

    // Storage carries no reset; contents are meaningless while empty.
    always_ff @(posedge clk_wr) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill     <= '0;
            r_overflow <= 1'b0;
            r_credit   <= 1'b0;
        end else if (!rx_online) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
            r_credit <= 1'b0;
        end else begin
            r_credit <= w_pop;
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_accept && !w_pop) begin
                r_fill <= r_fill + 1'b1;
            end else if (w_pop && !w_accept) begin
                r_fill <= r_fill - 1'b1;
            end
            if (w_push && !w_accept) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign w_head         = r_mem[r_rd_ptr];
    assign flit_valid     = (r_fill != '0);
    assign flit_data      = w_head.data;
    assign flit_protid    = w_head.protid;
    assign flit_crc       = w_head.crc;
    assign flit_crc_valid = w_head.crc_valid;
    assign flit_dvalid    = w_head.dvalid_mask;
    assign fill_level     = r_fill;
    assign overflow       = r_overflow;
    assign credit_return  = r_credit;

    lpif_ustrm_state_track u_state_track (
        .clk         (clk_wr),
        .rst         (rst_wr),
        .i_sample_en (rx_online),
        .i_state     (ustrm_state),
        .o_state     (flit_state),
        .o_state_chg (state_chg)
    );

endmodule
`default_nettype wire

// File: tb/tb_lpif_ustrm_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lpif_ustrm_rx_buffer
// Description : Scoreboard bench for lpif_ustrm_rx_buffer (DEPTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lpif_ustrm_rx_buffer;
    import lpif_ustrm_pkg::*;

    logic         clk_wr = 1'b0;
    logic         rst_wr;
    logic         rx_online;
    logic [7:0]   ustrm_state;
    logic [3:0]   ustrm_protid;
    logic [255:0] ustrm_data;
    logic [1:0]   ustrm_dvalid;
    logic [7:0]   ustrm_crc;
    logic [1:0]   ustrm_crc_valid;
    logic [1:0]   ustrm_valid;
    logic         flit_valid;
    logic         flit_ready;
    logic [255:0] flit_data;
    logic [3:0]   flit_protid;
    logic [7:0]   flit_crc;
    logic [1:0]   flit_crc_valid;
    logic [1:0]   flit_dvalid;
    logic [7:0]   flit_state;
    logic         state_chg;
    logic         credit_return;
    logic [3:0]   fill_level;
    logic         overflow;

    int n_tests = 0;
    int n_fail  = 0;
    int cred_cnt = 0;
    int chg_cnt  = 0;
    ustrm_entry_t exp_q[$];

    lpif_ustrm_rx_buffer #(.DEPTH(8)) dut (
        .clk_wr(clk_wr), .rst_wr(rst_wr), .rx_online(rx_online),
        .ustrm_state(ustrm_state), .ustrm_protid(ustrm_protid),
        .ustrm_data(ustrm_data), .ustrm_dvalid(ustrm_dvalid),
        .ustrm_crc(ustrm_crc), .ustrm_crc_valid(ustrm_crc_valid),
        .ustrm_valid(ustrm_valid), .flit_valid(flit_valid),
        .flit_ready(flit_ready), .flit_data(flit_data),
        .flit_protid(flit_protid), .flit_crc(flit_crc),
        .flit_crc_valid(flit_crc_valid), .flit_dvalid(flit_dvalid),
        .flit_state(flit_state), .state_chg(state_chg),
        .credit_return(credit_return), .fill_level(fill_level),
        .overflow(overflow)
    );

    always #5 clk_wr = ~clk_wr;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] mk_data(input int k);
        logic [15:0] s;
        s = k[15:0];
        return {8{s, ~s}};
    endfunction

    task automatic cycle();
        @(posedge clk_wr);
        #1;
    endtask

    // Drive one beat for one edge; queue its expected image if it should land.
    task automatic push_beat(input int k, input logic [1:0] v, input logic [1:0] dv,
                             input logic [1:0] cv, input logic [1:0] exp_dv,
                             input logic [1:0] exp_cv, input bit acc);
        ustrm_entry_t e;
        ustrm_valid     = v;
        ustrm_dvalid    = dv;
        ustrm_crc_valid = cv;
        ustrm_data      = mk_data(k);
        ustrm_protid    = k[3:0];
        ustrm_crc       = k[7:0] ^ 8'h5A;
        if (acc) begin
            e.dvalid_mask = exp_dv;
            e.crc_valid   = exp_cv;
            e.crc         = k[7:0] ^ 8'h5A;
            e.protid      = k[3:0];
            e.data        = mk_data(k);
            exp_q.push_back(e);
        end
        cycle();
    endtask

    task automatic push_full(input int k, input bit acc);
        push_beat(k, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, acc);
    endtask

    task automatic idle();
        ustrm_valid  = 2'b00;
        ustrm_dvalid = 2'b00;
    endtask

    task automatic drain();
        flit_ready = 1'b1;
        for (int i = 0; i < 20 && fill_level != 0; i++) cycle();
        check("drain_empty", 256'(fill_level), 256'd0);
        flit_ready = 1'b0;
        cycle();
        check("drain_queue_used", 256'(exp_q.size()), 256'd0);
    endtask

    // Monitor: a pop happens at the coming edge when these hold at negedge.
    always @(negedge clk_wr) begin
        if (credit_return) cred_cnt++;
        if (state_chg) chg_cnt++;
        if (!rst_wr && rx_online && flit_valid && flit_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", 256'd1, 256'd0);
            end else begin
                ustrm_entry_t e;
                e = exp_q.pop_front();
                check("flit_data", flit_data, e.data);
                check("flit_protid", 256'(flit_protid), 256'(e.protid));
                check("flit_crc", 256'(flit_crc), 256'(e.crc));
                check("flit_crc_valid", 256'(flit_crc_valid), 256'(e.crc_valid));
                check("flit_dvalid", 256'(flit_dvalid), 256'(e.dvalid_mask));
            end
        end
    end

    initial begin
        rst_wr = 1'b1; rx_online = 1'b0; ustrm_state = 8'h00;
        ustrm_protid = '0; ustrm_data = '0; ustrm_crc = '0;
        ustrm_crc_valid = '0; flit_ready = 1'b0;
        idle();
        repeat (3) cycle();
        check("rst_fill", 256'(fill_level), 256'd0);
        check("rst_flit_valid", 256'(flit_valid), 256'd0);
        check("rst_flit_state", 256'(flit_state), 256'd0);
        check("rst_state_chg", 256'(state_chg), 256'd0);
        check("rst_credit", 256'(credit_return), 256'd0);
        check("rst_overflow", 256'(overflow), 256'd0);
        rst_wr = 1'b0; rx_online = 1'b1;
        cycle();

        // Three beats held, then popped in order.
        for (int k = 1; k <= 3; k++) push_full(k, 1'b1);
        idle();
        check("three_fill", 256'(fill_level), 256'd3);
        check("three_valid", 256'(flit_valid), 256'd1);
        cred_cnt = 0;
        drain();
        check("three_credits", 256'(cred_cnt), 256'd3);

        // Fill to depth, overflow on the ninth, then push+pop at full.
        for (int k = 16; k < 24; k++) push_full(k, 1'b1);
        check("full_fill", 256'(fill_level), 256'd8);
        push_full(99, 1'b0);
        idle();
        check("ovf_flag", 256'(overflow), 256'd1);
        check("ovf_fill", 256'(fill_level), 256'd8);
        cred_cnt = 0;
        flit_ready = 1'b1;
        push_full(40, 1'b1);
        flit_ready = 1'b0;
        idle();
        check("full_pushpop_fill", 256'(fill_level), 256'd8);
        drain();
        check("full_credits", 256'(cred_cnt), 256'd9);

        // Half-valid beat masks dvalid and crc_valid.
        push_beat(50, 2'b01, 2'b11, 2'b11, 2'b01, 2'b01, 1'b1);
        push_beat(51, 2'b10, 2'b11, 2'b01, 2'b10, 2'b00, 1'b1);
        idle();
        drain();

        // State glitch and hold.
        chg_cnt = 0;
        ustrm_state = 8'h03;
        cycle();
`ifdef LPIF_USTRM_STATE_FILTER_EN
        check("glitch_state_n1", 256'(flit_state), 256'h00);
`else
        check("glitch_state_n1", 256'(flit_state), 256'h03);
`endif
        ustrm_state = 8'h00;
        cycle();
        check("glitch_state_n2", 256'(flit_state), 256'h00);
        cycle(); cycle();
`ifdef LPIF_USTRM_STATE_FILTER_EN
        check("glitch_pulses", 256'(chg_cnt), 256'd0);
`else
        check("glitch_pulses", 256'(chg_cnt), 256'd2);
`endif
        chg_cnt = 0;
        ustrm_state = 8'h03;
        cycle();
`ifdef LPIF_USTRM_STATE_FILTER_EN
        check("hold_state_n1", 256'(flit_state), 256'h00);
`else
        check("hold_state_n1", 256'(flit_state), 256'h03);
`endif
        cycle();
        check("hold_state_n2", 256'(flit_state), 256'h03);
        cycle();
        check("hold_pulses", 256'(chg_cnt), 256'd1);

        // Flush with five entries queued; state and overflow retained.
        for (int k = 60; k < 65; k++) push_full(k, 1'b1);
        idle();
        check("flush_pre_fill", 256'(fill_level), 256'd5);
        cred_cnt = 0;
        rx_online = 1'b0; flit_ready = 1'b1; ustrm_state = 8'h05;
        exp_q.delete();
        cycle();
        check("flush_fill", 256'(fill_level), 256'd0);
        check("flush_valid", 256'(flit_valid), 256'd0);
        check("flush_overflow", 256'(overflow), 256'd1);
        cycle();
        check("flush_state", 256'(flit_state), 256'h03);
        check("flush_credits", 256'(cred_cnt), 256'd0);
        flit_ready = 1'b0; ustrm_state = 8'h03; rx_online = 1'b1;
        cycle();

        // Streaming push/pop for 16 cycles wraps both pointers.
        flit_ready = 1'b1;
        for (int k = 100; k < 116; k++) push_full(k, 1'b1);
        idle();
        flit_ready = 1'b0;
        check("stream_fill", 256'(fill_level), 256'd1);
        drain();

        // Reset mid-stream overrides push and pop.
        push_full(120, 1'b1);
        push_full(121, 1'b1);
        rst_wr = 1'b1; flit_ready = 1'b1;
        exp_q.delete();
        push_full(122, 1'b0);
        idle();
        check("midrst_fill", 256'(fill_level), 256'd0);
        check("midrst_overflow", 256'(overflow), 256'd0);
        check("midrst_state", 256'(flit_state), 256'h00);
        rst_wr = 1'b0; flit_ready = 1'b0;
        cycle();
        check("post_rst_valid", 256'(flit_valid), 256'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lpif_ustrm_rx_buffer.md
# lpif_ustrm_rx_buffer

Elastic receive buffer directly downstream of the x4 asym1 half-rate LPIF master's upstream channel. It captures each `ustrm_*` beat into a small FIFO and presents a valid/ready flit interface to the adapter logic. It also tracks the received LPIF state with a change pulse and returns one credit per consumed entry. It supplies the flow control that the bypassed upstream path lacks.

## Interface
Parameters:
- `DEPTH`, 8 — FIFO entries; power of two, 2..64.
- `AW`, $clog2(DEPTH) — pointer width; derived, not overridden.

Ports:
- One clock; reset is synchronous and active-high.
- `clk_wr` in 1 — sole clock.
- `rst_wr` in 1 — synchronous active-high reset.
- `rx_online` in 1 — link online; low flushes the FIFO.
- `ustrm_state` in 8 — received LPIF state.
- `ustrm_protid` in 4 — protocol ID.
- `ustrm_data` in 256 — beat data; bit i of the valid masks qualifies `[128*i +: 128]`.
- `ustrm_dvalid` in 2 — per-half data valid.
- `ustrm_crc` in 8 — CRC, 4 bits per half.
- `ustrm_crc_valid` in 2 — per-half CRC valid.
- `ustrm_valid` in 2 — per-half beat valid.
- `flit_valid` out 1 — head entry available.
- `flit_ready` in 1 — consumer accepts head.
- `flit_data` out 256; `flit_protid` out 4; `flit_crc` out 8; `flit_crc_valid` out 2; `flit_dvalid` out 2 — head entry fields.
- `flit_state` out 8 — current tracked LPIF state.
- `state_chg` out 1 — one-cycle pulse when `flit_state` updates.
- `credit_return` out 1 — one-cycle pulse per popped entry.
- `fill_level` out AW+1 — current entry count.
- `overflow` out 1 — sticky dropped-beat flag.

## Operation
- Entry: {dvalid_mask, crc_valid, crc, protid, data}, 272 bits. `dvalid_mask` = `ustrm_valid & ustrm_dvalid`. `crc_valid` is stored as `ustrm_crc_valid & ustrm_valid`.
- push = `rx_online & |(ustrm_valid & ustrm_dvalid)`. pop = `flit_valid & flit_ready`.
- A push is accepted if `fill_level < DEPTH` or pop is asserted in the same cycle. Otherwise the beat is dropped and `overflow` is set; `fill_level` is unchanged.
- Simultaneous push and pop: both pointers advance and `fill_level` holds. This is legal at full and at 1.
- Pointers are AW bits and wrap modulo DEPTH. `fill_level` saturates arithmetic at 0..DEPTH, and counts never underflow.
- `flit_valid` = (`fill_level` != 0). Head fields come combinationally from `mem[rd_ptr]`. `flit_ready` is ignored while empty.
- `rx_online` low: pointers and `fill_level` clear next cycle; push is inhibited and no `credit_return` pulses are issued. `overflow` and `flit_state` are retained.
- State tracking: `ustrm_state` is sampled each cycle while `rx_online` is high. If the sample differs from `flit_state`, `flit_state` updates and `state_chg` pulses (subject to Configuration). State is tracked independently of push.
- `credit_return` is a register of pop.
- Reset values: pointers 0, `fill_level` 0, `flit_valid` 0, `flit_state` 8'h00, `state_chg` 0, `credit_return` 0, `overflow` 0. Memory is not reset; its contents are don't-care while empty.

## Timing
- Push at edge N → `flit_valid` high after edge N, so the entry is visible in cycle N+1.
- Pop at edge N → `credit_return` high during cycle N+1.
- State change on `ustrm_state` at cycle N → `flit_state`/`state_chg` in cycle N+1 without the filter, N+2 with it.
- Reset mid-operation takes effect at the next edge and overrides push, pop, and flush.

## Configuration
- `LPIF_USTRM_STATE_FILTER_EN` defined: a new state is committed only after two consecutive identical samples that differ from `flit_state`. Implement with a 1-deep candidate register plus a match bit; a single-cycle glitch produces no update and no pulse.
- Undefined: a single differing sample commits immediately, and the candidate logic is absent.

## Structure
- Shared package `lpif_ustrm_pkg`: `ustrm_entry_t` packed struct (272 b) and the `LPIF_STATE_RESET` = 8'h00 constant.
- One sub-module `lpif_ustrm_state_track`: state register, optional filter, and `state_chg`.
- The FIFO stays inline.

## Test plan
- Reset, then push 3 beats with `ustrm_valid`=2'b11 and `flit_ready`=0 → `fill_level`=3; after asserting ready, data pops in order with 3 `credit_return` pulses.
- Fill to DEPTH=8, then push a 9th beat with ready=0 → beat dropped, `overflow`=1, `fill_level`=8; push and pop in the same cycle at full → `fill_level` stays 8 and the new beat lands at the tail.
- `ustrm_valid`=2'b01 with `dvalid`=2'b11 → stored `flit_dvalid`=2'b01 and `flit_crc_valid` masked to bit 0.
- Deassert `rx_online` with 5 entries queued → `fill_level`=0 next cycle, no credits, `overflow` retained.
- `ustrm_state` 0→3 for one cycle then back to 0 → no filter: two `state_chg` pulses; with the macro: none. Holding 3 for 2 cycles with the macro → `flit_state`=3 two cycles later.
- 16 push/pop cycles with DEPTH=8 → pointers wrap and data integrity holds.
